// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response channel.
// The fetch stage drives ImemReq/ImemAddr (master); the memory answers with
// ImemReady on acceptance and ImemValid/ImemRData on the response (slave).
interface fetch_stage_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemReady;
  logic        ImemValid;
  logic [31:0] ImemRData;

  modport master (
    output ImemReq, ImemAddr,
    input  ImemReady, ImemValid, ImemRData
  );

  modport slave (
    input  ImemReq, ImemAddr,
    output ImemReady, ImemValid, ImemRData
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch and IF/ID pipeline register.
// Owns PCF, keeps at most one instruction-memory request outstanding and
// absorbs memory latency by inserting bubbles into Decode.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN. When defined, a redirect to
// a non-word-aligned target halts fetching and delivers a MisalignD marker;
// when undefined the target's low two bits are dropped and MisalignD is 0.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          StallF,
  input  logic          StallD,
  input  logic          FlushD,
  input  logic          PCSrcE,
  input  logic [31:0]   PCTargetE,
  fetch_stage_if.master imem,
  output logic [31:0]   InstrD,
  output logic [31:0]   PCD,
  output logic [31:0]   PCPlus4D,
  output logic          ValidD,
  output logic          MisalignD
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      stateReg, stateNext;
  logic [31:0] pcReg, pcNext, pcPlus4;
  logic [31:0] holdInstrReg, holdInstrNext;
  logic [31:0] targetPc;
  logic        accept;
  logic        loadAvail, loadMis, ifidLoad;
  logic [31:0] loadInstr;
  logic        haltReg, pendReg;

  assign pcPlus4 = pcReg + 32'd4;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic targetMisaligned;
  assign targetPc         = PCTargetE;
  assign targetMisaligned = (PCTargetE[1:0] != 2'b00);
`else
  assign targetPc  = {PCTargetE[31:2], 2'b00};
  assign haltReg   = 1'b0;
  assign pendReg   = 1'b0;
  assign MisalignD = 1'b0;
`endif

  // State, PC and hold buffer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg     <= S_REQ;
      pcReg        <= RESET_PC;
      holdInstrReg <= NOP_INSTR;
    end else begin
      stateReg     <= stateNext;
      pcReg        <= pcNext;
      holdInstrReg <= holdInstrNext;
    end
  end

  // Request generation, instruction availability and next-state logic.
  always_comb begin
    stateNext     = stateReg;
    pcNext        = pcReg;
    holdInstrNext = holdInstrReg;
    imem.ImemReq  = 1'b0;
    imem.ImemAddr = pcReg;
    loadAvail     = 1'b0;
    loadMis       = 1'b0;
    loadInstr     = NOP_INSTR;

    case (stateReg)
      S_REQ: begin
        imem.ImemReq = !StallF && !haltReg;
        // A pending misalignment marker is delivered while fetch is halted.
        if (pendReg) begin
          loadAvail = 1'b1;
          loadMis   = 1'b1;
        end
      end
      S_WAIT: begin
        // Back-to-back: the next request goes out in the response cycle.
        if (imem.ImemValid && !StallD) begin
          imem.ImemReq  = !StallF;
          imem.ImemAddr = pcPlus4;
          loadAvail     = 1'b1;
          loadInstr     = imem.ImemRData;
        end
      end
      S_HOLD: begin
        if (!StallD) begin
          loadAvail = 1'b1;
          loadInstr = holdInstrReg;
        end
      end
      default: ;
    endcase

    if (reset) imem.ImemReq = 1'b0;
    accept = imem.ImemReq && imem.ImemReady;

    if (PCSrcE) begin
      // Anything still in flight (or accepted now) belongs to the old path.
      pcNext = targetPc;
      if ((((stateReg == S_WAIT) || (stateReg == S_DROP)) && !imem.ImemValid) || accept)
        stateNext = S_DROP;
      else
        stateNext = S_REQ;
    end else begin
      case (stateReg)
        S_REQ: if (accept) stateNext = S_WAIT;
        S_WAIT: begin
          if (imem.ImemValid) begin
            if (!StallD) begin
              pcNext    = pcPlus4;
              stateNext = accept ? S_WAIT : S_REQ;
            end else begin
              holdInstrNext = imem.ImemRData;
              stateNext     = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!StallD) begin
            pcNext    = pcPlus4;
            stateNext = S_REQ;
          end
        end
        S_DROP: if (imem.ImemValid) stateNext = S_REQ;
        default: stateNext = S_REQ;
      endcase
    end

    ifidLoad = loadAvail && !FlushD && !PCSrcE && !StallD;
  end

  // IF/ID register: flush beats stall, stall beats load, otherwise bubble.
  always_ff @(posedge clk) begin
    if (reset || FlushD || PCSrcE) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      if (loadAvail) begin
        InstrD   <= loadInstr;
        PCD      <= pcReg;
        PCPlus4D <= pcPlus4;
        ValidD   <= 1'b1;
      end else begin
        InstrD   <= NOP_INSTR;
        PCD      <= 32'd0;
        PCPlus4D <= 32'd0;
        ValidD   <= 1'b0;
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Misalignment tracking: halt fetching until the next redirect and carry
  // the marker alongside the IF/ID entry it was delivered with.
  always_ff @(posedge clk) begin
    if (reset) begin
      haltReg   <= 1'b0;
      pendReg   <= 1'b0;
      MisalignD <= 1'b0;
    end else begin
      if (PCSrcE) begin
        haltReg <= targetMisaligned;
        pendReg <= targetMisaligned;
      end else if (ifidLoad && loadMis) begin
        pendReg <= 1'b0;
      end
      if (FlushD || PCSrcE)
        MisalignD <= 1'b0;
      else if (!StallD)
        MisalignD <= loadAvail && loadMis;
    end
  end
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the RV32I 5-stage pipeline. It owns the PC, issues requests to a variable-latency instruction memory with at most one outstanding request, and delivers instructions into Decode. It obeys the hazard unit's StallF, StallD and FlushD, and the Execute-stage redirect (PCSrcE/PCTargetE). Memory latency is absorbed by inserting bubbles into Decode, not by stalling the rest of the pipeline.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID on bubble or flush (addi x0,x0,0)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- StallF  input  1  hold PCF; issue no new request
- StallD  input  1  hold IF/ID contents
- FlushD  input  1  clear IF/ID to a bubble
- PCSrcE  input  1  redirect fetch to PCTargetE
- PCTargetE  input  32  redirect target
- ImemReq  output  1  request valid
- ImemAddr  output  32  request address
- ImemReady  input  1  memory accepts the request this cycle
- ImemValid  input  1  response valid, at least 1 cycle after acceptance
- ImemRData  input  32  response instruction
- InstrD  output  32  IF/ID instruction
- PCD  output  32  IF/ID PC
- PCPlus4D  output  32  PCD+4
- ValidD  output  1  IF/ID holds a real instruction
- MisalignD  output  1  see Configuration

## Operation
- PCF register. Address arithmetic is modulo 2^32; PCPlus4 wraps 32'hFFFF_FFFC to 0.
- FSM states:
  - REQ: ImemReq=!StallF, ImemAddr=PCF. On acceptance (ImemReq & ImemReady), go to WAIT.
  - WAIT: awaiting the response.
    - On ImemValid & !StallD, write {ImemRData, PCF, PCF+4, ValidD=1} into IF/ID and set PCF<=PCF+4.
    - In that same cycle, ImemReq=!StallF with ImemAddr=PCF+4 (combinational from ImemValid). If accepted, stay in WAIT; otherwise go to REQ.
    - On ImemValid & StallD, latch the response into the hold buffer and go to HOLD.
  - HOLD: ImemReq=0. When !StallD, move the hold buffer into IF/ID, set PCF<=PCF+4, and go to REQ.
  - DROP: ImemReq=0. When ImemValid arrives, discard the response and go to REQ.
- Redirect (PCSrcE=1) has priority over everything else:
  - PCF<=PCTargetE.
  - Hold buffer invalidated.
  - From WAIT with no response this cycle, or on a request accepted this cycle, go to DROP. Otherwise go to REQ.
  - A response arriving in the redirect cycle is discarded.
  - A request issued in the redirect cycle uses the old PC and is discarded through DROP.
- IF/ID update priority:
  1. FlushD, or PCSrcE: InstrD=NOP_INSTR, ValidD=0. PCD and PCPlus4D are don't-care, driven 0.
  2. StallD: hold.
  3. Instruction available (WAIT response or HOLD release): load it.
  4. Otherwise: bubble (NOP_INSTR, ValidD=0).
- StallF with !StallD: no new request is issued; PCF holds.

## Timing
- Reset values: PCF=RESET_PC, state=REQ, ImemReq=0 during reset, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, MisalignD=0, hold buffer empty.
- First ImemReq=1 appears in the first cycle after reset deasserts.
- Memory contract: no response is expected for any request issued before reset.
- Throughput: 1 instruction/cycle when ImemReady=1 and response latency is 1. Latency N gives 1 instruction per N cycles.
- Fetch-to-Decode: the instruction appears on InstrD one edge after its ImemValid cycle, or one edge after StallD falls when it was held.
- Redirect: target request issued the cycle after PCSrcE (REQ path), or after the stale response drains (DROP path).

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - A redirect with PCTargetE[1:0]!=0 still updates PCF, but the fetch is suppressed: no ImemReq is issued.
  - The next IF/ID load becomes {NOP_INSTR, PCD=target, ValidD=1, MisalignD=1}.
  - The FSM then stays in REQ with ImemReq=0 until the next redirect.
- Undefined:
  - MisalignD is tied to 0.
  - PCTargetE[1:0] is forced to 0 when loaded into PCF.

## Test plan
- Reset then ImemReady=1, 1-cycle latency, memory returns addr^32'hA5A5_0000: InstrD sequence for PCs 0,4,8,12 on consecutive cycles, ValidD=1 throughout.
- Latency 3: each instruction arrives every 3 cycles, with ValidD=0 and InstrD=32'h13 on the gap cycles.
- StallD=StallF=1 for 2 cycles while a response arrives: response held in HOLD, delivered when stall drops, with no duplicate and no lost PC.
- PCSrcE=1, PCTargetE=32'h100 while in WAIT with latency 2: stale response dropped, IF/ID flushed, next ValidD instruction has PCD=32'h100.
- PCF=32'hFFFF_FFFC fetch: PCPlus4D=0, and the next request address is 0.
- With FETCH_MISALIGN_CHECK_EN, redirect to 32'h102: no ImemReq is issued, then MisalignD=1, ValidD=1, PCD=32'h102.
